// File: rtl/ram_arb.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb
// Purpose  : Arbitrates one shared RAM (separate read and write ports) between
//            the instruction-fetch unit (read-only) and the load/store unit
//            (read or write). Only one transaction is in flight at a time.
//            Every transaction is IDLE (grant) -> ACCESS (one RAM cycle) ->
//            RESP (held until the owner accepts the response).
// Ports    : i_clk, i_rst_n          clock, asynchronous active-low reset
//            i_ifu_req_* / o_ifu_*   IFU read request and response channels
//            i_lsu_req_* / o_lsu_*   LSU read/write request and response
//            o_ram_rd_* / i_ram_rd_data  RAM read port (combinational data)
//            o_ram_wr_*              RAM write port with byte mask
// Config   : RAM_ARB_FIXED_PRIO_EN   if defined, the LSU always wins a tie and
//                                    the last-winner register is removed;
//                                    otherwise ties are resolved round-robin.
// Revision : 1.0  initial release
// ============================================================================
module ram_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    // IFU
    input  logic                    i_ifu_req_valid,
    output logic                    o_ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_ifu_req_addr,
    output logic                    o_ifu_resp_valid,
    output logic [DATA_WIDTH-1:0]   o_ifu_resp_data,
    input  logic                    i_ifu_resp_ready,
    // LSU
    input  logic                    i_lsu_req_valid,
    output logic                    o_lsu_req_ready,
    input  logic                    i_lsu_req_wen,
    input  logic [ADDR_WIDTH-1:0]   i_lsu_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_lsu_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_lsu_req_wmask,
    output logic                    o_lsu_resp_valid,
    output logic [DATA_WIDTH-1:0]   o_lsu_resp_data,
    input  logic                    i_lsu_resp_ready,
    // RAM
    output logic                    o_ram_rd_en,
    output logic [ADDR_WIDTH-1:0]   o_ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]   i_ram_rd_data,
    output logic                    o_ram_wr_en,
    output logic [ADDR_WIDTH-1:0]   o_ram_wr_addr,
    output logic [DATA_WIDTH-1:0]   o_ram_wr_data,
    output logic [DATA_WIDTH/8-1:0] o_ram_wr_mask
);

    localparam int c_MASK_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_owner_lsu;   // 0 = IFU owns the transaction
    logic                    r_wen;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_MASK_W-1:0]     r_wmask;
    logic [DATA_WIDTH-1:0]   r_resp_data;

    logic                    w_grant_lsu;
    logic                    w_grant_ifu;
    logic                    w_handshake;

    // ------------------------------------------------------------------------
    // Tie-break. The grant is only meaningful in IDLE; elsewhere the ready
    // outputs are forced low by the FSM block.
    // ------------------------------------------------------------------------
`ifdef RAM_ARB_FIXED_PRIO_EN
    assign w_grant_lsu = i_lsu_req_valid;
`else
    logic r_last_lsu;   // 1 = LSU won the most recent grant

    // LSU wins when it is alone, or on a tie when the IFU won last time.
    assign w_grant_lsu = i_lsu_req_valid & (~i_ifu_req_valid | ~r_last_lsu);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_lsu <= 1'b1;   // IFU takes the first tie after reset
        end else if (w_handshake) begin
            r_last_lsu <= w_grant_lsu;
        end
    end
`endif

    assign w_grant_ifu = i_ifu_req_valid & ~w_grant_lsu;
    assign w_handshake = (r_state == S_IDLE) & (w_grant_ifu | w_grant_lsu);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs. RAM enables and response valids are decoded
    // from the state register so an asynchronous reset removes them at once.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        o_ifu_req_ready  = 1'b0;
        o_lsu_req_ready  = 1'b0;
        o_ifu_resp_valid = 1'b0;
        o_ifu_resp_data  = '0;
        o_lsu_resp_valid = 1'b0;
        o_lsu_resp_data  = '0;
        o_ram_rd_en      = 1'b0;
        o_ram_rd_addr    = '0;
        o_ram_wr_en      = 1'b0;
        o_ram_wr_addr    = '0;
        o_ram_wr_data    = '0;
        o_ram_wr_mask    = '0;

        case (r_state)
            S_IDLE: begin
                o_ifu_req_ready = w_grant_ifu;
                o_lsu_req_ready = w_grant_lsu;
                if (w_handshake) begin
                    w_state_nxt = S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (r_wen) begin
                    // A zero mask still produces the write pulse.
                    o_ram_wr_en   = 1'b1;
                    o_ram_wr_addr = r_addr;
                    o_ram_wr_data = r_wdata;
                    o_ram_wr_mask = r_wmask;
                end else begin
                    o_ram_rd_en   = 1'b1;
                    o_ram_rd_addr = r_addr;
                end
                w_state_nxt = S_RESP;
            end

            S_RESP: begin
                if (r_owner_lsu) begin
                    o_lsu_resp_valid = 1'b1;
                    o_lsu_resp_data  = r_resp_data;
                    if (i_lsu_resp_ready) begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    o_ifu_resp_valid = 1'b1;
                    o_ifu_resp_data  = r_resp_data;
                    if (i_ifu_resp_ready) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request latch and response register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_owner_lsu <= 1'b0;
            r_wen       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_resp_data <= '0;
        end else begin
            if (w_handshake) begin
                r_owner_lsu <= w_grant_lsu;
                // The IFU is read-only, so its write enable is forced low.
                r_wen       <= w_grant_lsu & i_lsu_req_wen;
                r_addr      <= w_grant_lsu ? i_lsu_req_addr  : i_ifu_req_addr;
                r_wdata     <= w_grant_lsu ? i_lsu_req_wdata : '0;
                r_wmask     <= w_grant_lsu ? i_lsu_req_wmask : '0;
            end
            if (r_state == S_ACCESS) begin
                // Write acknowledgements carry zero data.
                r_resp_data <= r_wen ? '0 : i_ram_rd_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ram_arb.md
Name: ram_arb

Overview:
- Arbitrates one shared single-port-per-direction RAM between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read or write).
- Each requester uses valid/ready request and response channels.
- Sits between the core front-end/LSU and the RAM block; drives the RAM's read and write ports directly.
- One transaction in flight at a time; round-robin fairness.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, address width in bits; matches the RAM address port.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_ifu_req_valid  in  1  IFU read request valid
- o_ifu_req_ready  out  1  IFU request accepted this cycle
- i_ifu_req_addr  in  ADDR_WIDTH  IFU read address
- o_ifu_resp_valid  out  1  IFU read data valid
- o_ifu_resp_data  out  DATA_WIDTH  IFU read data
- i_ifu_resp_ready  in  1  IFU accepts response
- i_lsu_req_valid  in  1  LSU request valid
- o_lsu_req_ready  out  1  LSU request accepted this cycle
- i_lsu_req_wen  in  1  1 = write, 0 = read
- i_lsu_req_addr  in  ADDR_WIDTH  LSU address
- i_lsu_req_wdata  in  DATA_WIDTH  write data
- i_lsu_req_wmask  in  DATA_WIDTH/8  byte write enables
- o_lsu_resp_valid  out  1  LSU response valid (read data, or write ack)
- o_lsu_resp_data  out  DATA_WIDTH  read data; 0 for write acks
- i_lsu_resp_ready  in  1  LSU accepts response
- o_ram_rd_en  out  1  RAM read enable
- o_ram_rd_addr  out  ADDR_WIDTH  RAM read address
- i_ram_rd_data  in  DATA_WIDTH  RAM read data (combinational from address)
- o_ram_wr_en  out  1  RAM write enable
- o_ram_wr_addr  out  ADDR_WIDTH  RAM write address
- o_ram_wr_data  out  DATA_WIDTH  RAM write data
- o_ram_wr_mask  out  DATA_WIDTH/8  RAM byte mask

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values:
  - All resp_valid outputs 0; all RAM enables 0; all data/addr/mask outputs 0.
  - Grant owner register = IFU.
  - Last-winner register = LSU, so the IFU wins the first tie.
- IDLE:
  - Winner = the only valid requester; on a tie, the requester not equal to last-winner.
  - o_<winner>_req_ready = 1, combinational from valid. Ready is 0 in all other states and for the loser.
  - On handshake: latch owner, wen (forced 0 for IFU), addr, wdata, wmask; update last-winner; go to ACCESS.
  - No valid: stay in IDLE.
- ACCESS (exactly 1 cycle):
  - Read: o_ram_rd_en = 1, o_ram_rd_addr = latched addr; capture i_ram_rd_data into the response register at the clock edge.
  - Write: o_ram_wr_en = 1 with latched addr/data/mask for one cycle; response register = 0. A wmask of 0 still pulses wr_en.
  - Always go to RESP.
- RESP:
  - o_<owner>_resp_valid = 1 with the registered data; the other resp_valid stays 0.
  - Hold valid and data stable until <owner>_resp_ready = 1, then go to IDLE.
  - A new request is not accepted in the same cycle.
- Latency and throughput: request handshake in cycle N → resp_valid in cycle N+2. Minimum 3 cycles per transaction.
- RAM enables are never asserted outside ACCESS, and rd_en and wr_en are never high together.
- Address, data and mask pass through unmodified; no alignment checks.
- Requests that change or drop while not ready are ignored; nothing is latched without a handshake.
- Asynchronous reset mid-transaction:
  - Immediately return to IDLE and deassert all enables and resp_valid.
  - A pending write that has not reached ACCESS is never issued.
  - The response of an interrupted transaction is discarded.

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, LSU always wins ties; the last-winner register is not implemented.
- Undefined (default): round-robin as above.

Test Plan:
- Reset, then IFU read addr 0x10 (RAM returns 0xDEADBEEF): ready in cycle 0, o_ram_rd_en high in cycle 1 only, o_ifu_resp_valid with 0xDEADBEEF in cycle 2.
- LSU write addr 0x20, data 0x11223344, mask 4'b0101: one-cycle o_ram_wr_en with those values, then o_lsu_resp_valid with data 0. A later LSU read of 0x20 returns the RAM model's merged bytes.
- Both requesters valid continuously for 4 transactions: grants alternate IFU, LSU, IFU, LSU. With RAM_ARB_FIXED_PRIO_EN, all 4 grants go to LSU.
- Hold i_ifu_resp_ready = 0 for 5 cycles during RESP with an LSU request pending: o_ifu_resp_valid and data stay stable, o_lsu_req_ready stays 0, and the LSU is granted in the cycle after the IFU response handshake.
- Assert i_rst_n = 0 in ACCESS of an LSU write: o_ram_wr_en drops asynchronously, FSM returns to IDLE, no resp_valid appears, and the next request proceeds normally.
- Single LSU read with wen = 0 and wmask = all ones: o_ram_wr_en is never asserted.
